// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cook timer.
package oven_pkg;

    // Width of one BCD display digit.
    localparam int BCD_W = 4;

    // Top-level controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/oven_cook_timer_if.sv
// Front-panel bundle for the oven cook timer. The master side is the panel
// (keypad, buttons, door switch); the slave side is the timer itself.
interface oven_cook_timer_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          keyDigit;
    logic                keyValid;
    logic                startPause;
    logic                cancel;
    logic                doorOpen;
    logic [4*DIGITS-1:0] timeBcd;
    logic                running;
    logic                heating;
    logic                done;
    logic                beep;

    modport master (
        output keyDigit, keyValid, startPause, cancel, doorOpen,
        input  timeBcd, running, heating, done, beep
    );

    modport slave (
        input  keyDigit, keyValid, startPause, cancel, doorOpen,
        output timeBcd, running, heating, done, beep
    );
endinterface

// File: rtl/oven_cook_timer_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICK_DIV enabled
// cycles. clear restarts the count so the next tick is a full period away.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick: clear wins, otherwise count only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/oven_cook_timer.sv
// Oven cook timer: keypad time entry, start/pause/cancel control, mm:ss BCD
// countdown, and a done/beep phase. Seven-segment decoding lives elsewhere.
module oven_cook_timer
    import oven_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int BEEP_SEC  = 3,
    parameter int QUICK_SEC = 30
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [3:0]            keyDigit,
    input  logic                  keyValid,
    input  logic                  startPause,
    input  logic                  cancel,
    input  logic                  doorOpen,
    output logic [4*DIGITS-1:0]   timeBcd,
    output logic                  running,
    output logic                  heating,
    output logic                  done,
    output logic                  beep
);
    localparam int TW = DIGITS * BCD_W;

    // The beep phase is timed in clk cycles so the RUN prescaler can stay
    // frozen outside RUN.
    localparam int            BEEP_CYC  = BEEP_SEC * TICK_DIV;
    localparam int            BW        = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'((BEEP_CYC > 0) ? BEEP_CYC - 1 : 0);
    localparam logic          BEEP_ON   = (BEEP_SEC > 0);

    localparam logic [BCD_W-1:0] QUICK_TENS = BCD_W'(QUICK_SEC / 10);
    localparam logic [BCD_W-1:0] QUICK_ONES = BCD_W'(QUICK_SEC % 10);

    state_t         state_q, state_d;
    logic [TW-1:0]  time_q, time_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic           beep_q, beep_d;
    logic [BW-1:0]  beep_cnt_q, beep_cnt_d;

    logic           tick;
    logic           prescale_clear;
    logic [TW-1:0]  dec_time;
    logic [TW-1:0]  quick_time;
    logic           borrow;
    logic [BCD_W-1:0] dig [DIGITS];

    // View the display register as individual BCD digits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
        assign dig[gi] = time_q[gi*BCD_W +: BCD_W];
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .resetN (resetN),
        .enable (state_q == ST_RUN),
        .clear  (prescale_clear),
        .tick   (tick)
    );

    // One-second decrement: seconds borrow through 5, minutes are a plain
    // BCD down-counter. Seconds-tens above 5 just count down unnormalised.
    always_comb begin
        dec_time = time_q;
        borrow   = 1'b0;
        if (dig[0] != 4'd0) begin
            dec_time[3:0] = dig[0] - 4'd1;
        end else begin
            dec_time[3:0] = 4'd9;
            if (dig[1] != 4'd0) begin
                dec_time[7:4] = dig[1] - 4'd1;
            end else begin
                dec_time[7:4] = 4'd5;
                borrow        = 1'b1;
            end
        end
        for (int i = 2; i < DIGITS; i++) begin
            if (borrow) begin
                if (dig[i] != 4'd0) begin
                    dec_time[i*BCD_W +: BCD_W] = dig[i] - 4'd1;
                    borrow                     = 1'b0;
                end else begin
                    dec_time[i*BCD_W +: BCD_W] = 4'd9;
                end
            end
        end
    end

    // Quick-start value: QUICK_SEC in the seconds field, zero minutes.
    always_comb begin
        quick_time      = '0;
        quick_time[3:0] = QUICK_ONES;
        quick_time[7:4] = QUICK_TENS;
    end

    // Controller next-state: cancel overrides everything, then per-state rules.
    always_comb begin
        state_d        = state_q;
        time_d         = time_q;
        running_d      = running_q;
        done_d         = done_q;
        beep_d         = beep_q;
        beep_cnt_d     = beep_cnt_q;
        prescale_clear = 1'b0;

        if (cancel) begin
            state_d    = ST_IDLE;
            time_d     = '0;
            running_d  = 1'b0;
            done_d     = 1'b0;
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (startPause && !doorOpen) begin
                        state_d        = ST_RUN;
                        running_d      = 1'b1;
                        prescale_clear = 1'b1;
                        if (time_q == '0) begin
                            time_d = quick_time;
                        end
                    end else if (keyValid && (keyDigit <= 4'd9)) begin
                        time_d  = {time_q[TW-BCD_W-1:0], keyDigit};
                        state_d = ST_ENTRY;
                    end
                end
                ST_RUN: begin
                    if (startPause || doorOpen) begin
                        state_d   = ST_PAUSE;
                        running_d = 1'b0;
                    end else if (tick) begin
                        time_d = dec_time;
                        if (dec_time == '0) begin
                            state_d    = ST_DONE;
                            running_d  = 1'b0;
                            done_d     = 1'b1;
                            beep_d     = BEEP_ON;
                            beep_cnt_d = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (startPause && !doorOpen) begin
                        state_d        = ST_RUN;
                        running_d      = 1'b1;
                        prescale_clear = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (startPause || (beep_cnt_q == BEEP_LAST)) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b0;
                        beep_d     = 1'b0;
                        beep_cnt_d = '0;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BW'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    time_d    = '0;
                    running_d = 1'b0;
                    done_d    = 1'b0;
                    beep_d    = 1'b0;
                end
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            running_q  <= running_d;
            done_q     <= done_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign timeBcd = time_q;
    assign running = running_q;
    assign heating = running_q & ~doorOpen;
    assign done    = done_q;
    assign beep    = beep_q;
endmodule

// File: tb/tb_oven_cook_timer.sv
// Directed bench for oven_cook_timer with a 4-cycle tick.
module tb_oven_cook_timer;
    localparam int DIGITS    = 4;
    localparam int TICK_DIV  = 4;
    localparam int BEEP_SEC  = 3;
    localparam int QUICK_SEC = 30;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    oven_cook_timer_if #(.DIGITS(DIGITS)) bus ();

    oven_cook_timer #(
        .DIGITS    (DIGITS),
        .TICK_DIV  (TICK_DIV),
        .BEEP_SEC  (BEEP_SEC),
        .QUICK_SEC (QUICK_SEC)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .keyDigit   (bus.keyDigit),
        .keyValid   (bus.keyValid),
        .startPause (bus.startPause),
        .cancel     (bus.cancel),
        .doorOpen   (bus.doorOpen),
        .timeBcd    (bus.timeBcd),
        .running    (bus.running),
        .heating    (bus.heating),
        .done       (bus.done),
        .beep       (bus.beep)
    );

    typedef struct {
        logic [3:0]  key;
        logic        kv;
        logic        sp;
        logic        cn;
        logic        door;
        logic [15:0] t;
        logic        run;
        logic        dn;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one set of strobes for a single edge, then drop them.
    task automatic drive(input logic [3:0] k, input logic kv, input logic sp, input logic cn);
        bus.keyDigit   = k;
        bus.keyValid   = kv;
        bus.startPause = sp;
        bus.cancel     = cn;
        step();
        bus.keyValid   = 1'b0;
        bus.startPause = 1'b0;
        bus.cancel     = 1'b0;
    endtask

    task automatic add(input logic [3:0] k, input logic kv, input logic sp, input logic cn,
                       input logic door, input logic [15:0] t, input logic run, input logic dn);
        vec_t v;
        v.key = k; v.kv = kv; v.sp = sp; v.cn = cn; v.door = door;
        v.t = t; v.run = run; v.dn = dn;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;

        bus.keyDigit   = 4'd0;
        bus.keyValid   = 1'b0;
        bus.startPause = 1'b0;
        bus.cancel     = 1'b0;
        bus.doorOpen   = 1'b0;

        //   key  kv sp cn door time     run done
        add(4'hA, 1, 0, 0, 0, 16'h0000, 0, 0);  // illegal digit ignored
        add(4'h1, 1, 0, 0, 0, 16'h0001, 0, 0);
        add(4'h2, 1, 0, 0, 0, 16'h0012, 0, 0);
        add(4'h3, 1, 0, 0, 0, 16'h0123, 0, 0);
        add(4'h4, 1, 0, 0, 0, 16'h1234, 0, 0);
        add(4'h5, 1, 0, 0, 0, 16'h2345, 0, 0);  // top digit dropped
        add(4'h7, 1, 0, 1, 0, 16'h0000, 0, 0);  // cancel beats key
        add(4'h1, 1, 0, 0, 0, 16'h0001, 0, 0);
        add(4'h0, 1, 0, 0, 0, 16'h0010, 0, 0);
        add(4'h5, 1, 0, 0, 0, 16'h0105, 0, 0);
        add(4'h0, 0, 1, 0, 0, 16'h0105, 1, 0);  // start
        add(4'h0, 0, 0, 0, 0, 16'h0105, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0105, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0105, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0104, 1, 0);  // first tick, 4 clks after start
        add(4'h9, 1, 0, 0, 0, 16'h0104, 1, 0);  // key ignored in RUN
        add(4'h0, 0, 0, 0, 1, 16'h0104, 0, 0);  // door open -> PAUSE
        add(4'h0, 0, 1, 0, 1, 16'h0104, 0, 0);  // start ignored, door open
        add(4'h0, 0, 1, 0, 0, 16'h0104, 1, 0);  // resume
        add(4'h0, 0, 0, 0, 0, 16'h0104, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0104, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0104, 1, 0);
        add(4'h0, 0, 0, 0, 0, 16'h0103, 1, 0);  // exactly 4 clks after resume
        add(4'h0, 0, 1, 0, 0, 16'h0103, 0, 0);  // pause
        add(4'h0, 0, 1, 1, 0, 16'h0000, 0, 0);  // cancel beats start in PAUSE
        add(4'h0, 0, 1, 0, 0, 16'h0030, 1, 0);  // quick start from zero

        // Reset state, checked while reset is still held.
        #22;
        chk("reset_time", bus.timeBcd, 16'h0000);
        chk("reset_running", bus.running, 1'b0);
        chk("reset_heating", bus.heating, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_beep", bus.beep, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        step();

        foreach (vecs[i]) begin
            bus.doorOpen = vecs[i].door;
            drive(vecs[i].key, vecs[i].kv, vecs[i].sp, vecs[i].cn);
            $display("vec %0d: time=%h running=%b heating=%b done=%b", i,
                     bus.timeBcd, bus.running, bus.heating, bus.done);
            chk($sformatf("vec%0d_time", i), bus.timeBcd, vecs[i].t);
            chk($sformatf("vec%0d_running", i), bus.running, vecs[i].run);
            chk($sformatf("vec%0d_heating", i), bus.heating, vecs[i].run & ~vecs[i].door);
            chk($sformatf("vec%0d_done", i), bus.done, vecs[i].dn);
        end

        // Quick-start countdown: 30 ticks of 4 clks, then 3 ticks of beep.
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == 40) chk("quick_after_10_ticks", bus.timeBcd, 16'h0020);
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        $display("quick: done after %0d clks time=%h beep=%b", cyc, bus.timeBcd, bus.beep);
        chk("quick_done_cycle", cyc, 120);
        chk("quick_done_time", bus.timeBcd, 16'h0000);
        chk("quick_done_beep", bus.beep, 1'b1);
        chk("quick_done_running", bus.running, 1'b0);
        n = 0;
        while (bus.beep && n < 50) begin
            step();
            n++;
        end
        $display("beep: high for %0d more clks", n);
        chk("beep_length", n, 12);
        chk("after_beep_done", bus.done, 1'b0);
        chk("after_beep_time", bus.timeBcd, 16'h0000);

        // 1:00 -> 0:59 across the minutes borrow.
        drive(4'h0, 0, 0, 1);
        drive(4'h1, 1, 0, 0);
        drive(4'h0, 1, 0, 0);
        drive(4'h0, 1, 0, 0);
        drive(4'h0, 0, 1, 0);
        chk("borrow_start", bus.timeBcd, 16'h0100);
        repeat (4) step();
        $display("borrow: time=%h", bus.timeBcd);
        chk("borrow_0059", bus.timeBcd, 16'h0059);

        // 0:90 counts down without normalisation.
        drive(4'h0, 0, 0, 1);
        drive(4'h9, 1, 0, 0);
        drive(4'h0, 1, 0, 0);
        drive(4'h0, 0, 1, 0);
        repeat (4) step();
        $display("unnormalised: time=%h", bus.timeBcd);
        chk("unnorm_0089", bus.timeBcd, 16'h0089);

        // Start/pause in DONE silences beep and returns to IDLE.
        drive(4'h0, 0, 0, 1);
        drive(4'h1, 1, 0, 0);
        drive(4'h0, 0, 1, 0);
        repeat (4) step();
        chk("one_sec_done", bus.done, 1'b1);
        chk("one_sec_beep", bus.beep, 1'b1);
        chk("one_sec_time", bus.timeBcd, 16'h0000);
        drive(4'h0, 0, 1, 0);
        $display("done_abort: done=%b beep=%b", bus.done, bus.beep);
        chk("done_abort_done", bus.done, 1'b0);
        chk("done_abort_beep", bus.beep, 1'b0);
        drive(4'h6, 1, 0, 0);
        chk("done_abort_idle_key", bus.timeBcd, 16'h0006);

        // Asynchronous reset in the middle of a countdown.
        drive(4'h0, 0, 0, 1);
        drive(4'h4, 1, 0, 0);
        drive(4'h2, 1, 0, 0);
        drive(4'h0, 0, 1, 0);
        step();
        chk("prereset_running", bus.running, 1'b1);
        chk("prereset_time", bus.timeBcd, 16'h0042);
        #2 resetN = 1'b0;
        #1;
        $display("async reset: time=%h running=%b", bus.timeBcd, bus.running);
        chk("async_time", bus.timeBcd, 16'h0000);
        chk("async_running", bus.running, 1'b0);
        chk("async_heating", bus.heating, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (6) step();
        chk("post_reset_time", bus.timeBcd, 16'h0000);
        chk("post_reset_running", bus.running, 1'b0);
        drive(4'h7, 1, 0, 0);
        chk("post_reset_key", bus.timeBcd, 16'h0007);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
